eth_rx_header_parser: RTL and testbench

Byte-serial Ethernet II receive header parser, next generation of the MAC/ethertype cutter. Consumes one byte per clock framed by data_en and extracts destination MAC, source MAC, optional 802.1Q tag and full 16-bit ethertype. Classifies IPv4, ARP and IPv6, applies destination-MAC filtering, and forwards the payload as a qualified byte stream with start/end markers and a length count. Sits between the MAC receive byte interface and the IP/ARP handlers.

---
 rtl/eth_rx_header_parser.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_eth_rx_header_parser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_header_parser.sv
// Byte-serial Ethernet II receive header parser: extracts MACs, optional 802.1Q tag and ethertype,
// filters on destination MAC and type, and forwards the payload with sop/end markers and a length.
module eth_rx_header_parser #(
  parameter bit VLAN_EN      = 1'b1,
  parameter bit MAC_FILTER   = 1'b1,
  parameter bit ACCEPT_BCAST = 1'b1,
  parameter bit ACCEPT_MCAST = 1'b0,
  parameter bit TYPE_FILTER  = 1'b1,
  parameter int PLEN_W       = 11
) (
  input  logic              clock,
  input  logic              sclr,
  input  logic [7:0]        datain,
  input  logic              data_en,
  input  logic [47:0]       my_mac,
  output logic [47:0]       dst_mac,
  output logic [47:0]       src_mac,
  output logic [15:0]       ethertype,
  output logic [11:0]       vlan_id,
  output logic              has_vlan,
  output logic              is_ip,
  output logic              is_arp,
  output logic              is_ipv6,
  output logic              hdr_valid,
  output logic              drop,
  output logic              runt,
  output logic [7:0]        pl_data,
  output logic              pl_en,
  output logic              pl_sop,
  output logic              pkt_end,
  output logic [PLEN_W-1:0] pl_len
);

  // state    | meaning
  // SKIP     | after reset, wait for data_en low so a partial frame is ignored
  // IDLE     | between frames, first data_en byte is dst byte 0
  // DST/SRC  | destination / source MAC bytes
  // TYPE     | outer ethertype bytes
  // TCI      | 802.1Q tag control bytes
  // ITYPE    | inner ethertype bytes of a tagged frame
  // PAYLOAD  | accepted frame, forward bytes
  // DROP     | rejected frame, discard until data_en low
  typedef enum logic [3:0] {
    S_SKIP,
    S_IDLE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_TCI,
    S_ITYPE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t state, state_nx;

  logic [2:0]  fcnt, fcnt_nx;
  logic [47:0] sh_dst, sh_dst_nx;
  logic [47:0] sh_src, sh_src_nx;
  logic [15:0] sh_type, sh_type_nx;
  logic [11:0] sh_vid, sh_vid_nx;

  logic [47:0]       dst_nx, src_nx;
  logic [15:0]       type_nx;
  logic [11:0]       vid_nx;
  logic              has_vlan_nx, ip_nx, arp_nx, ipv6_nx;
  logic              hdr_valid_nx, drop_nx, runt_nx;
  logic [7:0]        pl_data_nx;
  logic              pl_en_nx, pl_sop_nx, pkt_end_nx;
  logic [PLEN_W-1:0] pl_len_nx;

  logic [15:0] type_word;
  logic        final_type;
  logic        mac_hit, mac_ok, known_type, type_ok;
  logic        t_ip, t_arp, t_ipv6;

  // Two-byte fields are shifted through sh_type; type_word is the field completed by the current byte.
  assign type_word  = {sh_type[7:0], datain};
  assign t_ip       = (type_word == 16'h0800);
  assign t_arp      = (type_word == 16'h0806);
  assign t_ipv6     = (type_word == 16'h86DD);
  assign known_type = t_ip | t_arp | t_ipv6;
  assign type_ok    = !TYPE_FILTER || known_type;

  assign mac_hit = (sh_dst == my_mac)
                || (ACCEPT_BCAST && (&sh_dst))
                || (ACCEPT_MCAST && sh_dst[40]);
  assign mac_ok  = !MAC_FILTER || mac_hit;

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) state <= S_SKIP;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    fcnt_nx      = fcnt;
    sh_dst_nx    = sh_dst;
    sh_src_nx    = sh_src;
    sh_type_nx   = sh_type;
    sh_vid_nx    = sh_vid;
    dst_nx       = dst_mac;
    src_nx       = src_mac;
    type_nx      = ethertype;
    vid_nx       = vlan_id;
    has_vlan_nx  = has_vlan;
    ip_nx        = is_ip;
    arp_nx       = is_arp;
    ipv6_nx      = is_ipv6;
    hdr_valid_nx = 1'b0;
    drop_nx      = 1'b0;
    runt_nx      = 1'b0;
    pl_data_nx   = pl_data;
    pl_en_nx     = 1'b0;
    pl_sop_nx    = 1'b0;
    pkt_end_nx   = 1'b0;
    pl_len_nx    = pl_len;
    final_type   = 1'b0;

    case (state)
      S_SKIP: begin
        if (!data_en) state_nx = S_IDLE;
      end

      S_IDLE: begin
        if (data_en) begin
          sh_dst_nx   = {sh_dst[39:0], datain};
          sh_vid_nx   = 12'd0;
          has_vlan_nx = 1'b0;
          ip_nx       = 1'b0;
          arp_nx      = 1'b0;
          ipv6_nx     = 1'b0;
          fcnt_nx     = 3'd1;
          state_nx    = S_DST;
        end
      end

      S_DST: begin
        if (data_en) begin
          sh_dst_nx = {sh_dst[39:0], datain};
          if (fcnt == 3'd5) begin
            fcnt_nx  = 3'd0;
            state_nx = S_SRC;
          end else begin
            fcnt_nx = fcnt + 3'd1;
          end
        end
      end

      S_SRC: begin
        if (data_en) begin
          sh_src_nx = {sh_src[39:0], datain};
          if (fcnt == 3'd5) begin
            fcnt_nx  = 3'd0;
            state_nx = S_TYPE;
          end else begin
            fcnt_nx = fcnt + 3'd1;
          end
        end
      end

      S_TYPE: begin
        if (data_en) begin
          sh_type_nx = type_word;
          if (fcnt == 3'd1) begin
            fcnt_nx = 3'd0;
            if (VLAN_EN && (type_word == 16'h8100)) begin
              has_vlan_nx = 1'b1;
              state_nx    = S_TCI;
            end else begin
              final_type = 1'b1;
            end
          end else begin
            fcnt_nx = 3'd1;
          end
        end
      end

      S_TCI: begin
        if (data_en) begin
          sh_type_nx = type_word;
          if (fcnt == 3'd1) begin
            fcnt_nx   = 3'd0;
            sh_vid_nx = type_word[11:0];
            state_nx  = S_ITYPE;
          end else begin
            fcnt_nx = 3'd1;
          end
        end
      end

      S_ITYPE: begin
        if (data_en) begin
          sh_type_nx = type_word;
          if (fcnt == 3'd1) begin
            fcnt_nx    = 3'd0;
            final_type = 1'b1;
          end else begin
            fcnt_nx = 3'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (data_en) begin
          pl_data_nx = datain;
          pl_en_nx   = 1'b1;
          pl_sop_nx  = (pl_len == '0);
          if (pl_len != {PLEN_W{1'b1}}) pl_len_nx = pl_len + 1'b1;
        end else begin
          pkt_end_nx = 1'b1;
          state_nx   = S_IDLE;
        end
      end

      S_DROP: begin
        if (!data_en) state_nx = S_IDLE;
      end

      default: state_nx = S_SKIP;
    endcase

    // Header truncated by a gap: report as runt and drop, back to IDLE.
    if (!data_en && (state == S_DST || state == S_SRC || state == S_TYPE ||
                     state == S_TCI || state == S_ITYPE)) begin
      runt_nx  = 1'b1;
      drop_nx  = 1'b1;
      fcnt_nx  = 3'd0;
      state_nx = S_IDLE;
    end

    if (final_type) begin
      ip_nx   = t_ip;
      arp_nx  = t_arp;
      ipv6_nx = t_ipv6;
      if (mac_ok && type_ok) begin
        hdr_valid_nx = 1'b1;
        dst_nx       = sh_dst;
        src_nx       = sh_src;
        type_nx      = type_word;
        vid_nx       = sh_vid;
        pl_len_nx    = '0;
        state_nx     = S_PAYLOAD;
      end else begin
        drop_nx  = 1'b1;
        state_nx = S_DROP;
      end
    end
  end

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      fcnt      <= 3'd0;
      sh_dst    <= 48'd0;
      sh_src    <= 48'd0;
      sh_type   <= 16'd0;
      sh_vid    <= 12'd0;
      dst_mac   <= 48'd0;
      src_mac   <= 48'd0;
      ethertype <= 16'd0;
      vlan_id   <= 12'd0;
      has_vlan  <= 1'b0;
      is_ip     <= 1'b0;
      is_arp    <= 1'b0;
      is_ipv6   <= 1'b0;
      hdr_valid <= 1'b0;
      drop      <= 1'b0;
      runt      <= 1'b0;
      pl_data   <= 8'd0;
      pl_en     <= 1'b0;
      pl_sop    <= 1'b0;
      pkt_end   <= 1'b0;
      pl_len    <= '0;
    end else begin
      fcnt      <= fcnt_nx;
      sh_dst    <= sh_dst_nx;
      sh_src    <= sh_src_nx;
      sh_type   <= sh_type_nx;
      sh_vid    <= sh_vid_nx;
      dst_mac   <= dst_nx;
      src_mac   <= src_nx;
      ethertype <= type_nx;
      vlan_id   <= vid_nx;
      has_vlan  <= has_vlan_nx;
      is_ip     <= ip_nx;
      is_arp    <= arp_nx;
      is_ipv6   <= ipv6_nx;
      hdr_valid <= hdr_valid_nx;
      drop      <= drop_nx;
      runt      <= runt_nx;
      pl_data   <= pl_data_nx;
      pl_en     <= pl_en_nx;
      pl_sop    <= pl_sop_nx;
      pkt_end   <= pkt_end_nx;
      pl_len    <= pl_len_nx;
    end
  end

endmodule

// File: tb/tb_eth_rx_header_parser.sv
// Bench for eth_rx_header_parser: frame-level model fills a per-cycle expectation table,
// one negedge process compares the DUT against it, plus literal field checks.
module tb_eth_rx_header_parser;

  localparam int N = 8192;
  localparam logic [47:0] MY_MAC = 48'h020000000001;
  localparam logic [47:0] SRC_A  = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

  logic        clock, sclr, data_en;
  logic [7:0]  datain;
  logic [47:0] my_mac;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic [11:0] vlan_id;
  logic        has_vlan, is_ip, is_arp, is_ipv6;
  logic        hdr_valid, drop, runt;
  logic [7:0]  pl_data;
  logic        pl_en, pl_sop, pkt_end;
  logic [10:0] pl_len;

  eth_rx_header_parser dut (
    .clock(clock), .sclr(sclr), .datain(datain), .data_en(data_en), .my_mac(my_mac),
    .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype), .vlan_id(vlan_id),
    .has_vlan(has_vlan), .is_ip(is_ip), .is_arp(is_arp), .is_ipv6(is_ipv6),
    .hdr_valid(hdr_valid), .drop(drop), .runt(runt), .pl_data(pl_data), .pl_en(pl_en),
    .pl_sop(pl_sop), .pkt_end(pkt_end), .pl_len(pl_len)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit run = 0;

  // Expectations indexed by the posedge count after which the output is visible.
  bit          e_hdr[N], e_drop[N], e_runt[N], e_en[N], e_sop[N], e_end[N], e_fl[N];
  logic [7:0]  e_data[N];
  int          e_len[N];
  logic [47:0] e_dst[N], e_src[N];
  logic [15:0] e_type[N];
  logic [11:0] e_vid[N];
  bit          e_vlan[N], e_ip[N], e_arp[N], e_v6[N];

  logic [7:0] fr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_hdr[i] = 0; e_drop[i] = 0; e_runt[i] = 0; e_en[i] = 0;
      e_sop[i] = 0; e_end[i] = 0; e_fl[i] = 0;
    end
  endtask

  task automatic build(input logic [47:0] d, input logic [47:0] s, input bit tag,
                       input logic [15:0] tci, input logic [15:0] ty, input int npl,
                       input logic [7:0] base);
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(s[47-8*i -: 8]);
    if (tag) begin
      fr.push_back(8'h81); fr.push_back(8'h00);
      fr.push_back(tci[15:8]); fr.push_back(tci[7:0]);
    end
    fr.push_back(ty[15:8]); fr.push_back(ty[7:0]);
    for (int j = 0; j < npl; j++) fr.push_back(8'(base + j));
  endtask

  task automatic truncate(input int len);
    while (fr.size() > len) void'(fr.pop_back());
  endtask

  // Frame-level model: header length, filter verdict, payload stream and final length.
  task automatic model_frame(input int t0);
    int L, H, plen;
    logic [15:0] ot, ty;
    logic [47:0] d, s;
    logic [11:0] vid;
    bit tag, ip, arp, v6, ok;
    L = fr.size();
    if (L < 14) begin
      e_runt[t0+L] = 1; e_drop[t0+L] = 1; e_fl[t0+L] = 1;
      e_vlan[t0+L] = 0; e_ip[t0+L] = 0; e_arp[t0+L] = 0; e_v6[t0+L] = 0;
      return;
    end
    ot  = {fr[12], fr[13]};
    tag = (ot == 16'h8100);
    if (tag && L < 18) begin
      e_runt[t0+L] = 1; e_drop[t0+L] = 1; e_fl[t0+L] = 1;
      e_vlan[t0+L] = 1; e_ip[t0+L] = 0; e_arp[t0+L] = 0; e_v6[t0+L] = 0;
      return;
    end
    H   = tag ? 18 : 14;
    ty  = tag ? {fr[16], fr[17]} : ot;
    vid = tag ? {fr[14][3:0], fr[15]} : 12'd0;
    d = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
    s = {fr[6], fr[7], fr[8], fr[9], fr[10], fr[11]};
    ip  = (ty == 16'h0800);
    arp = (ty == 16'h0806);
    v6  = (ty == 16'h86DD);
    ok  = (d == MY_MAC || d == BCAST) && (ip || arp || v6);
    e_fl[t0+H-1] = 1; e_vlan[t0+H-1] = tag;
    e_ip[t0+H-1] = ip; e_arp[t0+H-1] = arp; e_v6[t0+H-1] = v6;
    if (ok) begin
      e_hdr[t0+H-1]  = 1;
      e_dst[t0+H-1]  = d;
      e_src[t0+H-1]  = s;
      e_type[t0+H-1] = ty;
      e_vid[t0+H-1]  = vid;
      for (int j = 0; j < L - H; j++) begin
        e_en[t0+H+j]   = 1;
        e_sop[t0+H+j]  = (j == 0);
        e_data[t0+H+j] = fr[H+j];
      end
      plen = L - H;
      if (plen > 2047) plen = 2047;
      e_end[t0+L] = 1;
      e_len[t0+L] = plen;
    end else begin
      e_drop[t0+H-1] = 1;
    end
  endtask

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
    chk({tag, "_pl_en"},     64'(pl_en),     64'd0);
    chk({tag, "_pl_len"},    64'(pl_len),    64'd0);
    chk({tag, "_dst_mac"},   64'(dst_mac),   64'd0);
    chk({tag, "_ethertype"}, 64'(ethertype), 64'd0);
    chk({tag, "_is_ip"},     64'(is_ip),     64'd0);
    chk({tag, "_pl_data"},   64'(pl_data),   64'd0);
  endtask

  // Drives fr, then holds data_en low for gap cycles; abort_at >= 0 pulses sclr mid-frame.
  task automatic send_frame(input int gap, input int abort_at);
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clock); #1;
      if (i == 0) model_frame(cyc + 1);
      datain  = fr[i];
      data_en = 1'b1;
      if (i == abort_at) begin
        sclr = 1'b1;
        clear_from(cyc);
        #1;
        reset_zero_checks("midrst");
      end
      if (abort_at >= 0 && i == abort_at + 2) sclr = 1'b0;
    end
    @(posedge clock); #1;
    data_en = 1'b0;
    datain  = 8'h00;
    repeat (gap - 1) @(posedge clock);
  endtask

  always @(negedge clock) begin
    if (run && cyc < N) begin
      chk("hdr_valid", 64'(hdr_valid), 64'(e_hdr[cyc]));
      chk("drop",      64'(drop),      64'(e_drop[cyc]));
      chk("runt",      64'(runt),      64'(e_runt[cyc]));
      chk("pl_en",     64'(pl_en),     64'(e_en[cyc]));
      chk("pl_sop",    64'(pl_sop),    64'(e_sop[cyc]));
      chk("pkt_end",   64'(pkt_end),   64'(e_end[cyc]));
      if (e_en[cyc])  chk("pl_data", 64'(pl_data), 64'(e_data[cyc]));
      if (e_end[cyc]) chk("pl_len",  64'(pl_len),  64'(e_len[cyc]));
      if (e_hdr[cyc]) begin
        chk("dst_mac",   64'(dst_mac),   64'(e_dst[cyc]));
        chk("src_mac",   64'(src_mac),   64'(e_src[cyc]));
        chk("ethertype", 64'(ethertype), 64'(e_type[cyc]));
        chk("vlan_id",   64'(vlan_id),   64'(e_vid[cyc]));
      end
      if (e_fl[cyc]) begin
        chk("has_vlan", 64'(has_vlan), 64'(e_vlan[cyc]));
        chk("is_ip",    64'(is_ip),    64'(e_ip[cyc]));
        chk("is_arp",   64'(is_arp),   64'(e_arp[cyc]));
        chk("is_ipv6",  64'(is_ipv6),  64'(e_v6[cyc]));
      end
    end
  end

  initial begin
    sclr    = 1'b1;
    data_en = 1'b0;
    datain  = 8'h00;
    my_mac  = MY_MAC;
    clear_from(0);
    #1;
    reset_zero_checks("reset");
    run = 1;
    repeat (3) @(posedge clock);
    #1 sclr = 1'b0;
    repeat (2) @(posedge clock);

    // Untagged IPv4 to my_mac, payload 00..09
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h0800, 10, 8'h00);
    send_frame(3, -1);
    #1;
    chk("lit_ipv4_pl_len", 64'(pl_len),    64'd10);
    chk("lit_ipv4_type",   64'(ethertype), 64'h0800);
    chk("lit_ipv4_dst",    64'(dst_mac),   64'h020000000001);
    chk("lit_ipv4_is_ip",  64'(is_ip),     64'd1);

    // Broadcast ARP accepted, same to a foreign MAC dropped
    build(BCAST, SRC_A, 0, 16'h0, 16'h0806, 4, 8'h40);
    send_frame(1, -1);
    build(48'h020000000099, SRC_A, 0, 16'h0, 16'h0806, 4, 8'h50);
    send_frame(2, -1);
    #1;
    chk("lit_arp_pl_len_held", 64'(pl_len), 64'd4);
    chk("lit_arp_is_arp",      64'(is_arp),  64'd1);

    // Tagged: TCI 0x6064, inner IPv6
    build(MY_MAC, SRC_A, 1, 16'h6064, 16'h86DD, 6, 8'hA0);
    send_frame(2, -1);
    #1;
    chk("lit_vlan_vid",   64'(vlan_id),   64'h064);
    chk("lit_vlan_has",   64'(has_vlan),  64'd1);
    chk("lit_vlan_type",  64'(ethertype), 64'h86DD);
    chk("lit_vlan_ipv6",  64'(is_ipv6),   64'd1);
    chk("lit_vlan_len",   64'(pl_len),    64'd6);

    // Unknown type dropped; fields hold
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h0801, 3, 8'h10);
    send_frame(2, -1);
    #1;
    chk("lit_unk_is_ip",   64'(is_ip),     64'd0);
    chk("lit_unk_is_ipv6", 64'(is_ipv6),   64'd0);
    chk("lit_unk_type",    64'(ethertype), 64'h86DD);

    // Runt after 9 bytes, and runt inside the tag
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h0800, 0, 8'h00);
    truncate(9);
    send_frame(2, -1);
    build(MY_MAC, SRC_A, 1, 16'h0123, 16'h0800, 0, 8'h00);
    truncate(16);
    send_frame(2, -1);

    // Reset mid-payload, released while data_en high; next frame parsed normally
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h0800, 20, 8'h60);
    send_frame(3, 20);
    build(MY_MAC, 48'h112233445566, 0, 16'h0, 16'h0800, 5, 8'h70);
    send_frame(2, -1);
    #1;
    chk("lit_postrst_len", 64'(pl_len),  64'd5);
    chk("lit_postrst_src", 64'(src_mac), 64'h112233445566);

    // Back-to-back with a single idle cycle
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h0806, 3, 8'h80);
    send_frame(1, -1);
    build(BCAST, SRC_A, 0, 16'h0, 16'h0800, 7, 8'h90);
    send_frame(1, -1);

    // Header-only frame, tagged frame with inner 0x8100
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h86DD, 0, 8'h00);
    send_frame(2, -1);
    #1;
    chk("lit_hdronly_len", 64'(pl_len), 64'd0);
    build(MY_MAC, SRC_A, 1, 16'h0005, 16'h8100, 2, 8'h00);
    send_frame(2, -1);

    // Length saturation
    build(MY_MAC, SRC_A, 0, 16'h0, 16'h0800, 2100, 8'h00);
    send_frame(3, -1);
    #1;
    chk("lit_sat_len", 64'(pl_len), 64'd2047);

    repeat (5) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
